// File: rtl/dds_pkg.sv
// dds_pkg: shared types and sample-format helpers for the DAC sample feeder.
`default_nettype none

package dds_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } feeder_state_t;

  // Idle DAC code: zero volts in the chosen output format.
  function automatic logic [31:0] mid_val(input int unsigned dw, input bit offbin);
    return offbin ? (32'd1 << (dw - 1)) : 32'd0;
  endfunction

  // Offset-binary is two's complement with the sign bit flipped.
  function automatic logic [31:0] to_dac(input logic [31:0] d, input int unsigned dw,
                                         input bit offbin);
    return d ^ mid_val(dw, offbin);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: first-word-fall-through FIFO, wrap-bit pointers, occupancy and flush.
`default_nettype none

module sync_fifo_fwft #(
  parameter int DW    = 10,
  parameter int DEPTH = 8
) (
  input  logic                     PLL_CLK,
  input  logic                     RESETn,
  input  logic                     i_push,
  input  logic [DW-1:0]            i_data,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [DW-1:0]            o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_one = (AW + 1)'(1);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW:0]   r_wr;
  logic [AW:0]   r_rd;
  logic          w_push;
  logic          w_pop;

  // A flush discards any push arriving in the same cycle.
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & ~o_empty & ~i_flush;

  always_ff @(posedge PLL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + c_one;
      if (w_pop)  r_rd <= r_rd + c_one;
    end
  end

  always_ff @(posedge PLL_CLK) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  assign o_head  = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_level = r_wr - r_rd;

endmodule

`default_nettype wire

// File: rtl/dac_sample_feeder.sv
// dac_sample_feeder: buffers DDS samples and presents them on the DAC bus on Dac_CLK-aligned
// slots tracked by an internal phase bit (mirror of Fg_CLK).
`default_nettype none

module dac_sample_feeder
  import dds_pkg::*;
#(
  parameter int DW         = 10,
  parameter int DEPTH      = 8,
  parameter int PRIME_LVL  = 4,
  parameter int OUT_OFFBIN = 1,
  parameter int UFLOW_HOLD = 1
) (
  input  logic                     PLL_CLK,
  input  logic                     RESETn,
  input  logic                     en,
  input  logic                     s_valid,
  input  logic [DW-1:0]            s_data,
  output logic                     s_ready,
  output logic [DW-1:0]            dac_data,
  output logic                     uflow,
  input  logic                     uflow_clr,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [DW-1:0] c_mid = DW'(mid_val(DW, OUT_OFFBIN != 0));
  localparam logic [LW-1:0] c_prime = LW'(PRIME_LVL);

  feeder_state_t r_state;
  feeder_state_t w_state_nxt;
  logic          r_ph;
  logic [DW-1:0] r_dac;
  logic [DW-1:0] w_dac_nxt;
  logic          r_uflow;
  logic          w_uflow_set;
  logic          w_pop;
  logic          w_flush;
  logic [DW-1:0] w_head;
  logic [DW-1:0] w_head_dac;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;

  sync_fifo_fwft #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .PLL_CLK (PLL_CLK),
    .RESETn  (RESETn),
    .i_push  (s_valid),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_head_dac = DW'(to_dac(32'(w_head), DW, OUT_OFFBIN != 0));

  // Flushing only outside IDLE lets the FIFO be pre-loaded while the stream is disabled.
  always_comb begin
    w_state_nxt = r_state;
    w_dac_nxt   = r_dac;
    w_pop       = 1'b0;
    w_flush     = 1'b0;
    w_uflow_set = 1'b0;
    if (!en && (r_state != ST_IDLE)) begin
      w_flush = 1'b1;
      if (r_ph) begin
        w_dac_nxt   = c_mid;
        w_state_nxt = ST_IDLE;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (en) w_state_nxt = ST_PRIME;
        end
        ST_PRIME: begin
          if (r_ph && (w_level >= c_prime)) begin
            w_pop       = 1'b1;
            w_dac_nxt   = w_head_dac;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (r_ph) begin
            if (!w_empty) begin
              w_pop     = 1'b1;
              w_dac_nxt = w_head_dac;
            end else begin
              w_uflow_set = 1'b1;
              w_dac_nxt   = (UFLOW_HOLD != 0) ? r_dac : c_mid;
              w_state_nxt = ST_PRIME;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge PLL_CLK or negedge RESETn) begin
    if (!RESETn) begin
      r_ph    <= 1'b0;
      r_state <= ST_IDLE;
      r_dac   <= c_mid;
      r_uflow <= 1'b0;
    end else begin
      r_ph    <= ~r_ph;
      r_state <= w_state_nxt;
      r_dac   <= w_dac_nxt;
      if (w_uflow_set)    r_uflow <= 1'b1;
      else if (uflow_clr) r_uflow <= 1'b0;
    end
  end

  assign s_ready  = ~w_full;
  assign dac_data = r_dac;
  assign uflow    = r_uflow;
  assign level    = w_level;

endmodule

`default_nettype wire

// File: tb/tb_dac_sample_feeder.sv
// tb_dac_sample_feeder: directed bench with hand-computed expected DAC codes and levels.
`default_nettype none

module tb_dac_sample_feeder;
  import dds_pkg::*;

  logic       PLL_CLK   = 1'b0;
  logic       RESETn    = 1'b0;
  logic       en        = 1'b0;
  logic       s_valid   = 1'b0;
  logic [9:0] s_data    = '0;
  logic       uflow_clr = 1'b0;
  logic       s_ready;
  logic [9:0] dac_data;
  logic       uflow;
  logic [3:0] level;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  dac_sample_feeder #(
    .DW         (10),
    .DEPTH      (8),
    .PRIME_LVL  (4),
    .OUT_OFFBIN (1),
    .UFLOW_HOLD (1)
  ) dut (
    .PLL_CLK   (PLL_CLK),
    .RESETn    (RESETn),
    .en        (en),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .dac_data  (dac_data),
    .uflow     (uflow),
    .uflow_clr (uflow_clr),
    .level     (level)
  );

  always #5 PLL_CLK = ~PLL_CLK;

  task automatic tick();
    @(posedge PLL_CLK);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s (cyc %0d): observed %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  initial begin
    #12;
    chk("rst_dac", 32'(dac_data), 32'h200);
    chk("rst_ready", 32'(s_ready), 32'd1);
    chk("rst_uflow", 32'(uflow), 32'd0);
    chk("rst_level", 32'(level), 32'd0);

    // Stream 1..4 through PRIME into RUN
    RESETn = 1'b1; en = 1'b1; s_valid = 1'b1; s_data = 10'h001;
    tick(); s_data = 10'h002;
    tick(); s_data = 10'h003;
    tick(); s_data = 10'h004;
    tick(); s_valid = 1'b0;
    chk("prime_level", 32'(level), 32'd4);
    chk("prime_dac", 32'(dac_data), 32'h200);
    tick();
    chk("prime_hold", 32'(dac_data), 32'h200);
    tick();
    chk("run_state", 32'(dut.r_state), 32'(ST_RUN));
    for (int k = 6; k <= 13; k++) begin
      chk("stream_dac", 32'(dac_data), 32'h201 + 32'((k - 6) / 2));
      tick();
    end

    // Underflow holds last sample and returns to PRIME
    chk("uf_dac", 32'(dac_data), 32'h204);
    chk("uf_flag", 32'(uflow), 32'd1);
    chk("uf_level", 32'(level), 32'd0);
    chk("uf_state", 32'(dut.r_state), 32'(ST_PRIME));
    uflow_clr = 1'b1;
    tick(); uflow_clr = 1'b0;
    chk("uf_clr", 32'(uflow), 32'd0);

    // Refill with -1, 0, 5, 6
    s_valid = 1'b1; s_data = 10'h3FF;
    tick(); s_data = 10'h000;
    tick(); s_data = 10'h005;
    tick(); s_data = 10'h006;
    tick(); s_valid = 1'b0;
    chk("refill_level", 32'(level), 32'd4);
    chk("refill_hold", 32'(dac_data), 32'h204);
    tick();
    chk("neg1_dac", 32'(dac_data), 32'h1FF);
    chk("neg1_level", 32'(level), 32'd3);
    s_valid = 1'b1; s_data = 10'h007;
    tick(); s_data = 10'h008;
    chk("neg1_hold", 32'(dac_data), 32'h1FF);
    tick(); s_data = 10'h009;
    chk("zero_dac", 32'(dac_data), 32'h200);
    chk("pushpop_level", 32'(level), 32'd4);
    tick(); s_data = 10'h00A;
    chk("lvl5", 32'(level), 32'd5);
    tick();
    chk("five_dac", 32'(dac_data), 32'h205);
    chk("five_level", 32'(level), 32'd5);

    // Drop en mid-RUN on a non-slot edge; push in that cycle is dropped
    en = 1'b0; s_data = 10'h00B;
    tick(); s_valid = 1'b0;
    chk("flush_level", 32'(level), 32'd0);
    chk("flush_dac", 32'(dac_data), 32'h205);
    tick();
    chk("stop_dac", 32'(dac_data), 32'h200);
    chk("stop_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("stop_level", 32'(level), 32'd0);

    // Pre-load while disabled until full
    s_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_data = 10'h010 + 10'(k);
      tick();
    end
    chk("full_level", 32'(level), 32'd8);
    chk("full_ready", 32'(s_ready), 32'd0);
    s_data = 10'h3AA;
    tick();
    tick();
    chk("full_ignore", 32'(level), 32'd8);
    s_valid = 1'b0; en = 1'b1;
    tick();
    tick();
    chk("full_head", 32'(dac_data), 32'h210);
    chk("full_pop", 32'(level), 32'd7);

    // Asynchronous reset mid-RUN
    RESETn = 1'b0;
    #1;
    chk("arst_dac", 32'(dac_data), 32'h200);
    chk("arst_ready", 32'(s_ready), 32'd1);
    chk("arst_uflow", 32'(uflow), 32'd0);
    chk("arst_level", 32'(level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
